// File: rtl/regfile_pkg.sv
// Shared widths, index/data types and architectural register numbers for the
// integer register file with busy scoreboard.
package regfile_pkg;

    localparam int DATA_WIDTH_DEF = 32;
    localparam int ADDR_WIDTH_DEF = 5;

    typedef logic [ADDR_WIDTH_DEF-1:0] reg_idx_t;
    typedef logic [DATA_WIDTH_DEF-1:0] reg_data_t;

    // x0 is hardwired to zero; x10 (a0) is the default debug tap.
    localparam reg_idx_t ZERO_REG = reg_idx_t'(0);
    localparam reg_idx_t A0_REG   = reg_idx_t'(10);

endpackage : regfile_pkg

// File: rtl/regfile_scoreboard.sv
// Per-register busy scoreboard: issue sets a destination busy, write-back
// clears it, flush clears everything. Also keeps a registered count of busy
// registers. Register 0 is never busy.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    localparam int DEPTH     = 2 ** ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic                  iss_en,
    input  logic [ADDR_WIDTH-1:0] iss_addr,
    input  logic                  flush,
    output logic [DEPTH-1:0]      busy,
    output logic [ADDR_WIDTH:0]   busy_cnt
);

    logic [DEPTH-1:0]    busy_d, busy_q;
    logic [ADDR_WIDTH:0] busy_cnt_d, busy_cnt_q;

    // Next busy vector: flush beats everything; otherwise clear then set, so
    // a same-index issue (the newer producer) wins over the clearing write.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        busy_d = busy_q;
        if (flush) begin
            busy_d = '0;
        end else begin
            if (wr_en && (wr_addr != '0)) begin
                busy_d[wr_addr] = 1'b0;
            end
            if (iss_en && (iss_addr != '0)) begin
                busy_d[iss_addr] = 1'b1;
            end
        end
        busy_d[0] = 1'b0;
    end

    // Popcount of the next-state vector so the count matches busy after the edge.
    always_comb begin
        busy_cnt_d = '0;
        for (int i = 0; i < DEPTH; i++) begin
            busy_cnt_d = busy_cnt_d + {{ADDR_WIDTH{1'b0}}, busy_d[i]};
        end
    end

    // Busy state and count registers.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples its pre-edge inputs regardless of block ordering.
        if (!rst_n) begin
            busy_q     <= '0;
            busy_cnt_q <= '0;
        end else begin
            busy_q     <= busy_d;
            busy_cnt_q <= busy_cnt_d;
        end
    end

    assign busy     = busy_q;
    assign busy_cnt = busy_cnt_q;

endmodule : regfile_scoreboard

// File: rtl/regfile_sb.sv
// Integer register file with NUM_READ asynchronous read ports, optional
// write-to-read bypass, a busy scoreboard for in-flight destinations and a
// debug tap on one fixed register.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int NUM_READ   = 2,
    parameter int BYPASS     = 1,
    parameter int TAP_REG    = 10
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_READ*ADDR_WIDTH-1:0] rd_addr,
    output logic [NUM_READ*DATA_WIDTH-1:0] rd_data,
    output logic [NUM_READ-1:0]            rd_busy,
    input  logic                           wr_en,
    input  logic [ADDR_WIDTH-1:0]          wr_addr,
    input  logic [DATA_WIDTH-1:0]          wr_data,
    input  logic                           iss_en,
    input  logic [ADDR_WIDTH-1:0]          iss_addr,
    input  logic                           flush,
    output logic [ADDR_WIDTH:0]            busy_cnt,
    output logic [DATA_WIDTH-1:0]          tap
);

    localparam int                  DEPTH   = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] TAP_IDX = ADDR_WIDTH'(TAP_REG);

    logic [DATA_WIDTH-1:0] mem_d [DEPTH];
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DEPTH-1:0]      busy;

    regfile_scoreboard #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_scoreboard (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .iss_en   (iss_en),
        .iss_addr (iss_addr),
        .flush    (flush),
        .busy     (busy),
        .busy_cnt (busy_cnt)
    );

    // Next storage contents: one write per cycle, x0 is never written.
    always_comb begin
        mem_d = mem_q;
        if (wr_en && (wr_addr != '0)) begin
            mem_d[wr_addr] = wr_data;
        end
    end

    // Storage array.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: the array is reset because the architecture requires every
        // register to read zero after reset; a RAM macro could not do this.
        if (!rst_n) begin
            mem_q <= '{default: '0};
        end else begin
            mem_q <= mem_d;
        end
    end

    // Read ports: stored value, or the in-flight write data when bypassing.
    // A bypassed write also hides the busy bit it is about to clear.
    always_comb begin : rd_mux
        logic [ADDR_WIDTH-1:0] ra;
        logic                  hit;
        rd_data = '0;
        rd_busy = '0;
        ra      = '0;
        hit     = 1'b0;
        for (int i = 0; i < NUM_READ; i++) begin
            ra  = rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
            hit = (BYPASS != 0) && wr_en && (wr_addr == ra) && (ra != '0);
            rd_data[i*DATA_WIDTH +: DATA_WIDTH] = hit ? wr_data : mem_q[ra];
            rd_busy[i] = busy[ra] & ~hit;
        end
    end

    // Debug tap always shows the stored value, never the bypass.
    assign tap = mem_q[TAP_IDX];

endmodule : regfile_sb

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: one bypassing and one non-bypassing instance
// driven by the same stimulus, checked against hand-computed values.
module tb_regfile_sb;
    import regfile_pkg::*;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [NR*AW-1:0] rd_addr;
    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [DW-1:0]    wr_data;
    logic             iss_en;
    logic [AW-1:0]    iss_addr;
    logic             flush;

    logic [NR*DW-1:0] rd_data_bp, rd_data_nb;
    logic [NR-1:0]    rd_busy_bp, rd_busy_nb;
    logic [AW:0]      busy_cnt_bp, busy_cnt_nb;
    logic [DW-1:0]    tap_bp, tap_nb;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    regfile_sb #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_READ(NR), .BYPASS(1), .TAP_REG(10)) u_dut_bp (
        .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data_bp), .rd_busy(rd_busy_bp),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .iss_en(iss_en), .iss_addr(iss_addr),
        .flush(flush), .busy_cnt(busy_cnt_bp), .tap(tap_bp)
    );

    regfile_sb #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_READ(NR), .BYPASS(0), .TAP_REG(10)) u_dut_nb (
        .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data_nb), .rd_busy(rd_busy_nb),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .iss_en(iss_en), .iss_addr(iss_addr),
        .flush(flush), .busy_cnt(busy_cnt_nb), .tap(tap_nb)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic set_rd(input reg_idx_t a0, input reg_idx_t a1);
        rd_addr = {a1, a0};
    endtask

    task automatic idle();
        wr_en = 1'b0; iss_en = 1'b0; flush = 1'b0;
    endtask

    // Advance past the next rising edge and return inputs to idle.
    task automatic tick();
        @(posedge clk);
        #1;
        idle();
    endtask

    initial begin
        rst_n = 1'b0; idle();
        wr_addr = '0; wr_data = '0; iss_addr = '0; rd_addr = '0;

        // Reset state on every index, both ports
        #2;
        for (int i = 0; i < 32; i++) begin
            set_rd(reg_idx_t'(i), reg_idx_t'(31 - i));
            #0.1;
            check($sformatf("rst_rd_x%0d", i), {rd_data_bp, rd_data_nb}, 64'h0);
            check($sformatf("rst_busy_x%0d", i), {rd_busy_bp, rd_busy_nb}, 64'h0);
        end
        check("rst_cnt", {busy_cnt_bp, busy_cnt_nb}, 64'h0);
        check("rst_tap", {tap_bp, tap_nb}, 64'h0);
        @(negedge clk); rst_n = 1'b1;

        // Write x5 with same-cycle read: bypass vs. stored value
        @(negedge clk);
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF; set_rd(5'd5, 5'd0);
        #1;
        check("byp_rd_x5", rd_data_bp[31:0], 64'hDEADBEEF);
        check("nobyp_rd_x5", rd_data_nb[31:0], 64'h0);
        tick();
        check("byp_rd_x5_after", rd_data_bp[31:0], 64'hDEADBEEF);
        check("nobyp_rd_x5_after", rd_data_nb[31:0], 64'hDEADBEEF);

        // Writes and issues to x0 are ignored
        @(negedge clk);
        wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFFFFFF;
        iss_en = 1'b1; iss_addr = 5'd0; set_rd(5'd0, 5'd0);
        #1;
        check("x0_rd_same", {rd_data_bp, rd_data_nb[31:0]}, 64'h0);
        tick();
        check("x0_rd", {rd_data_bp, rd_data_nb[31:0]}, 64'h0);
        check("x0_busy", {rd_busy_bp, rd_busy_nb}, 64'h0);
        check("x0_cnt", {busy_cnt_bp, busy_cnt_nb}, 64'h0);

        // Issue x7, then write it back while reading
        @(negedge clk);
        iss_en = 1'b1; iss_addr = 5'd7;
        tick();
        set_rd(5'd5, 5'd7);
        #1;
        check("x7_busy", {rd_busy_bp, rd_busy_nb}, 64'b1010);
        check("x7_cnt", {busy_cnt_bp, busy_cnt_nb}, {52'h0, 6'd1, 6'd1});
        @(negedge clk);
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h12;
        #1;
        check("x7_wb_busy_bp", rd_busy_bp, 64'b00);
        check("x7_wb_busy_nb", rd_busy_nb, 64'b10);
        check("x7_wb_rd_bp", rd_data_bp[63:32], 64'h12);
        check("x7_wb_rd_nb", rd_data_nb[63:32], 64'h0);
        check("x7_wb_cnt_pre", busy_cnt_bp, 64'd1);
        tick();
        check("x7_cnt_after", {busy_cnt_bp, busy_cnt_nb}, 64'h0);
        check("x7_rd_after", {rd_data_bp[63:32], rd_data_nb[63:32]}, 64'h00000012_00000012);
        check("x7_busy_after", {rd_busy_bp, rd_busy_nb}, 64'h0);

        // Same-edge write and issue on x3: set wins
        @(negedge clk);
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h33;
        iss_en = 1'b1; iss_addr = 5'd3;
        tick();
        set_rd(5'd3, 5'd6);
        #1;
        check("x3_busy", {rd_busy_bp, rd_busy_nb}, 64'b0101);
        check("x3_rd", rd_data_nb[31:0], 64'h33);
        check("x3_cnt", busy_cnt_bp, 64'd1);

        // Issue x1, x2, x4, then re-issue busy x3 (WAW keeps one bit)
        @(negedge clk); iss_en = 1'b1; iss_addr = 5'd1; tick();
        @(negedge clk); iss_en = 1'b1; iss_addr = 5'd2; tick();
        @(negedge clk); iss_en = 1'b1; iss_addr = 5'd4; tick();
        @(negedge clk); iss_en = 1'b1; iss_addr = 5'd3; tick();
        check("multi_cnt", {busy_cnt_bp, busy_cnt_nb}, {52'h0, 6'd4, 6'd4});

        // Flush with concurrent issue x6 and write x9
        @(negedge clk);
        flush = 1'b1; iss_en = 1'b1; iss_addr = 5'd6;
        wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h99;
        tick();
        check("flush_cnt", {busy_cnt_bp, busy_cnt_nb}, 64'h0);
        check("flush_busy", {rd_busy_bp, rd_busy_nb}, 64'h0);
        set_rd(5'd9, 5'd4);
        #1;
        check("flush_wr_x9", rd_data_nb[31:0], 64'h99);
        check("flush_busy_x4", {rd_busy_bp, rd_busy_nb}, 64'h0);

        // Tap follows x10 one edge after the write, never bypassed
        @(negedge clk);
        wr_en = 1'b1; wr_addr = A0_REG; wr_data = 32'h2A;
        iss_en = 1'b1; iss_addr = 5'd8;
        #1;
        check("tap_pre", {tap_bp, tap_nb}, 64'h0);
        tick();
        check("tap_post", {tap_bp, tap_nb}, 64'h0000002A_0000002A);
        check("tap_cnt", busy_cnt_bp, 64'd1);

        // Asynchronous reset between edges clears everything at once
        @(negedge clk);
        set_rd(A0_REG, 5'd8);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_tap", {tap_bp, tap_nb}, 64'h0);
        check("arst_cnt", {busy_cnt_bp, busy_cnt_nb}, 64'h0);
        check("arst_rd", {rd_data_bp[31:0], rd_data_nb[31:0]}, 64'h0);
        check("arst_busy", {rd_busy_bp, rd_busy_nb}, 64'h0);
        @(negedge clk); rst_n = 1'b1;

        // First edge after reset behaves normally
        @(negedge clk);
        wr_en = 1'b1; wr_addr = 5'd31; wr_data = 32'hA5A5_0001;
        iss_en = 1'b1; iss_addr = 5'd30;
        tick();
        set_rd(5'd31, 5'd30);
        #1;
        check("post_rst_rd", rd_data_nb[31:0], 64'hA5A50001);
        check("post_rst_busy", {rd_busy_bp, rd_busy_nb}, 64'b1010);
        check("post_rst_cnt", busy_cnt_nb, 64'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_regfile_sb
